// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: walks one low column at a time, debounces
// press and release on the synchronized rows, and emits one hex code per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 250000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_N = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(MAX_N) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state, state_next;
  logic [3:0]       rows_p0, rows_p1;
  logic [1:0]       col, col_next;
  logic [1:0]       row, row_next;
  logic [CNT_W-1:0] dwell, dwell_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept, release_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  function automatic logic single_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_comb begin
    state_next   = state;
    col_next     = col;
    row_next     = row;
    dwell_next   = dwell;
    cnt_next     = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          if (single_low(rows_p1)) begin
            row_next   = low_index(rows_p1);
            cnt_next   = CNT_ONE;
            state_next = DEBOUNCE;
          end else begin
            col_next = col + 2'd1;
          end
        end else begin
          dwell_next = sat_inc(dwell);
        end
      end
      DEBOUNCE: begin
        // The whole row pattern must stay one-hot on the latched row.
        if (rows_p1 == ~(4'b0001 << row)) begin
          cnt_next = sat_inc(cnt);
          if (cnt == DEB_LAST) begin
            accept     = 1'b1;
            cnt_next   = '0;
            state_next = HELD;
          end
        end else begin
          cnt_next   = '0;
          dwell_next = '0;
          col_next   = col + 2'd1;
          state_next = SCAN;
        end
      end
      HELD: begin
        if (rows_p1[row]) begin
          cnt_next   = CNT_ONE;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (rows_p1[row]) begin
          cnt_next = sat_inc(cnt);
          if (cnt == DEB_LAST) begin
            release_done = 1'b1;
            cnt_next     = '0;
            dwell_next   = '0;
            col_next     = col + 2'd1;
            state_next   = SCAN;
          end
        end else begin
          cnt_next   = '0;
          state_next = HELD;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      dwell     <= '0;
      cnt       <= '0;
      cols      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      rows_p0   <= 4'hF;
      rows_p1   <= 4'hF;
    end else begin
      // sync stage p0 -> p1
      rows_p0   <= rows;
      rows_p1   <= rows_p0;
      // scan/debounce control stage
      state     <= state_next;
      col       <= col_next;
      row       <= row_next;
      dwell     <= dwell_next;
      cnt       <= cnt_next;
      cols      <= col_drive(col_next);
      key_valid <= accept;
      if (accept) begin
        key_code <= key_map(row, col);
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad switch-matrix model, per-cycle behavioural reference
// checked on every falling edge, plus directed scenarios with literal expectations.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int P_SCAN = 0, P_CONF = 1, P_HOLD = 2, P_REL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows, cols, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys = '0;   // bit r*4+c is the switch at row r, column c

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // A closed switch shorts its row to its column; only a driven-low column pulls a row low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [3:0] walk [4]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  function automatic int n_low(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) n++;
    return n;
  endfunction

  function automatic int low_row(input logic [3:0] v);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) idx = i;
    return idx;
  endfunction

  // Reference: predicts the outputs after the coming rising edge from the rows seen now.
  int         m_phase = P_SCAN, m_col = 0, m_tick = 0, m_row = 0, m_run = 0;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  logic [3:0] e_cols = 4'b1110, e_code = 4'h0;
  logic       e_valid = 1'b0, e_held = 1'b0;
  bit         m_ready = 1'b0;

  always @(negedge clk) begin
    if (m_ready) begin
      check("cols", cols, e_cols);
      check("key_valid", key_valid, e_valid);
      check("key_held", key_held, e_held);
      check("key_code", key_code, e_code);
    end
    if (!reset) begin
      m_phase = P_SCAN; m_col = 0; m_tick = 0; m_run = 0; m_row = 0;
      m_s1 = 4'hF; m_s2 = 4'hF;
      e_code = 4'h0; e_valid = 1'b0; e_held = 1'b0;
      m_ready = 1'b1;
    end else begin
      e_valid = 1'b0;
      case (m_phase)
        P_SCAN: begin
          if (m_tick == SCAN_DIV - 1) begin
            if (n_low(m_s2) == 1) begin
              m_row = low_row(m_s2); m_run = 1; m_phase = P_CONF;
            end else begin
              m_col = (m_col + 1) % 4; m_tick = 0;
            end
          end else m_tick++;
        end
        P_CONF: begin
          if (n_low(m_s2) == 1 && !m_s2[m_row]) begin
            m_run++;
            if (m_run == DEB) begin
              e_code = keymap[m_row*4 + m_col]; e_valid = 1'b1; e_held = 1'b1; m_phase = P_HOLD;
            end
          end else begin
            m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_tick = 0;
          end
        end
        P_HOLD: if (m_s2[m_row]) begin m_phase = P_REL; m_run = 1; end
        P_REL: begin
          if (m_s2[m_row]) begin
            m_run++;
            if (m_run == DEB) begin
              e_held = 1'b0; m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_tick = 0;
            end
          end else m_phase = P_HOLD;
        end
        default: ;
      endcase
      m_s2 = m_s1;
      m_s1 = rows;
    end
    e_cols = walk[m_col];
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_count(input int n, output int pulses, output logic [3:0] code);
    pulses = 0;
    code   = 4'h0;
    repeat (n) begin
      cyc(1);
      if (key_valid) begin pulses++; code = key_code; end
    end
  endtask

  task automatic wait_phase(input int ph, input string name);
    int k = 0;
    while (m_phase != ph && k < 200) begin cyc(1); k++; end
    check(name, int'(m_phase == ph), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p;
    logic [3:0] code;

    reset = 1'b0;
    cyc(2);
    check("rst_cols", cols, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 4'h0);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      check("cols_walk", cols, walk[(k/4)%4]);
    end

    // '6' at r1/c2, held steady
    keys[1*4+2] = 1'b1;
    run_count(40, p, code);
    check("six_pulses", p, 1);
    check("six_code", code, 4'h6);
    check("six_held", key_held, 1);
    check("six_cols", cols, 4'b1011);
    run_count(100, p, code);
    check("six_hold_pulses", p, 0);
    check("six_hold_cols", cols, 4'b1011);
    check("six_hold_held", key_held, 1);
    keys = '0;
    cyc(9);
    check("six_rel_early", key_held, 1);
    cyc(1);
    check("six_rel_done", key_held, 0);
    check("six_rel_cols", cols, 4'b0111);

    // '0' at r3/c1 with contact bounce, then steady
    p = 0;
    for (int i = 0; i < 20; i++) begin
      keys[3*4+1] = ((i / 3) % 2 == 0);
      cyc(1);
      if (key_valid) p++;
    end
    check("zero_bounce_pulses", p, 0);
    keys[3*4+1] = 1'b1;
    run_count(60, p, code);
    check("zero_pulses", p, 1);
    check("zero_code", code, 4'h0);
    keys = '0;
    run_count(30, p, code);
    check("zero_released", key_held, 0);

    // r0/c0 and r2/c0 together are ignored; dropping r2 leaves '1'
    keys[0*4+0] = 1'b1;
    keys[2*4+0] = 1'b1;
    run_count(60, p, code);
    check("multi_pulses", p, 0);
    check("multi_held", key_held, 0);
    keys[2*4+0] = 1'b0;
    run_count(40, p, code);
    check("one_pulses", p, 1);
    check("one_code", code, 4'h1);
    keys = '0;
    run_count(30, p, code);

    // 'D' at r3/c3: reset during debounce, then during hold
    keys[3*4+3] = 1'b1;
    wait_phase(P_CONF, "reach_debounce");
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rdeb_valid", key_valid, 0);
    check("rdeb_held", key_held, 0);
    check("rdeb_cols", cols, 4'b1110);
    check("rdeb_code", key_code, 4'h0);
    reset = 1'b1;
    wait_phase(P_HOLD, "reach_held");
    check("d_valid", key_valid, 1);
    check("d_code", key_code, 4'hD);
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rheld_valid", key_valid, 0);
    check("rheld_held", key_held, 0);
    check("rheld_cols", cols, 4'b1110);
    check("rheld_code", key_code, 4'h0);
    keys = '0;
    reset = 1'b1;
    run_count(20, p, code);
    check("post_reset_pulses", p, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
